// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioning path.
// Holds no logic: state encoding, default timing constants and a small helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, async active-high reset.
// Latency: 2 clk edges; no backpressure (samples every cycle).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw button pin into a level plus press/release/long-press pulses and a mode flag.
// Latency: press/release follow DEBOUNCE_CYCLES+2 edges after the pin settles; no backpressure.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic mode_sel
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       sync_q;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic long_done_q, long_done_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_press_q, long_press_d;
  logic mode_sel_q, mode_sel_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_in),
    .q   (sync_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_done_q  <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      mode_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_done_q  <= long_done_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
      mode_sel_q   <= mode_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_done_d  = long_done_q;
    level_d      = level_q;
    mode_sel_d   = mode_sel_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = CNT_ONE;
        end
      end

      DB_PRESS: begin
        if (!sync_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LIMIT) begin
          state_d    = PRESSED;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (sync_q) begin
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_d == LP_LIMIT) begin
            state_d      = HELD;
            long_done_d  = 1'b1;
            long_press_d = 1'b1;
            mode_sel_d   = ~mode_sel_q;
          end
        end else begin
          // hold_cnt is left alone so a release bounce resumes the count
          state_d  = DB_RELEASE;
          db_cnt_d = CNT_ONE;
        end
      end

      HELD: begin
        if (!sync_q) begin
          state_d  = DB_RELEASE;
          db_cnt_d = CNT_ONE;
        end
      end

      DB_RELEASE: begin
        if (sync_q) begin
          state_d  = long_done_q ? HELD : PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LIMIT) begin
          state_d     = IDLE;
          db_cnt_d    = '0;
          long_done_d = 1'b0;
          level_d     = 1'b0;
          release_d   = 1'b1;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_press_q;
  assign mode_sel      = mode_sel_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: fixed vector table, directed corner sequences,
// then random bouncy stimulus against a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst;
  logic button_in;
  logic level, press, release_pulse, long_press, mode_sel;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_in     (button_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .mode_sel      (mode_sel)
  );

  typedef struct {
    logic btn;
    logic lv;
    logic pr;
    logic rl;
    logic lp;
    logic md;
  } vec_t;

  vec_t tbl[$];

  // Reference model: debounced level changes once the synchronised pin has
  // held its new value for D+1 consecutive edges; hold time counts edges where
  // the synchronised pin was high on both this and the previous edge.
  logic m_h1, m_h2, m_prev;
  int   ones_run, zeros_run, hold;
  logic m_level, m_press, m_rel, m_long, m_mode, m_long_done;

  function automatic void model_reset();
    m_h1 = 0; m_h2 = 0; m_prev = 0;
    ones_run = 0; zeros_run = 0; hold = 0;
    m_level = 0; m_press = 0; m_rel = 0; m_long = 0; m_mode = 0; m_long_done = 0;
  endfunction

  function automatic void model_edge(input logic b);
    logic s;
    s    = m_h2;
    m_h2 = m_h1;
    m_h1 = b;
    m_press = 0; m_rel = 0; m_long = 0;
    if (s) begin ones_run++; zeros_run = 0; end
    else begin zeros_run++; ones_run = 0; end
    if (!m_level) begin
      if (ones_run == D + 1) begin
        m_level = 1; m_press = 1; hold = 0; m_long_done = 0;
      end
    end else if (zeros_run == D + 1) begin
      m_level = 0; m_rel = 1;
    end else if (s && m_prev && !m_long_done) begin
      hold++;
      if (hold == L) begin
        m_long = 1; m_long_done = 1; m_mode = ~m_mode;
      end
    end
    m_prev = s;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_level"},   level,         m_level);
    chk({tag, "_press"},   press,         m_press);
    chk({tag, "_release"}, release_pulse, m_rel);
    chk({tag, "_long"},    long_press,    m_long);
    chk({tag, "_mode"},    mode_sel,      m_mode);
  endtask

  // Called at posedge+1; drives the pin, takes one edge, returns at posedge+1.
  task automatic step(input logic b);
    button_in = b;
    @(posedge clk);
    if (!rst) model_edge(b);
    #1;
  endtask

  function automatic void add_vec(input logic btn, input logic lv, input logic pr,
                                  input logic rl, input logic lp, input logic md);
    vec_t v;
    v.btn = btn; v.lv = lv; v.pr = pr; v.rl = rl; v.lp = lp; v.md = md;
    tbl.push_back(v);
  endfunction

  task automatic do_reset(input logic btn);
    rst = 1'b1;
    button_in = btn;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] bounce;
    logic       lvl;
    int         len;

    rst = 1'b1;
    button_in = 1'b0;
    model_reset();
    #1;
    chk("reset_level",   level,         1'b0);
    chk("reset_press",   press,         1'b0);
    chk("reset_release", release_pulse, 1'b0);
    chk("reset_long",    long_press,    1'b0);
    chk("reset_mode",    mode_sel,      1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean press held 8 cycles, clean release, then a rejected bounce burst.
    for (int i = 0; i < 8; i++) add_vec(1'b1, i >= 6, i == 6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add_vec(1'b0, i < 6, 1'b0, i == 6, 1'b0, 1'b0);
    bounce = 7'b1010110;
    for (int i = 6; i >= 0; i--) add_vec(bounce[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn);
      chk($sformatf("tbl%0d_level", i),   level,         tbl[i].lv);
      chk($sformatf("tbl%0d_press", i),   press,         tbl[i].pr);
      chk($sformatf("tbl%0d_release", i), release_pulse, tbl[i].rl);
      chk($sformatf("tbl%0d_long", i),    long_press,    tbl[i].lp);
      chk($sformatf("tbl%0d_mode", i),    mode_sel,      tbl[i].md);
    end

    // Long press: press at E6, long_press and mode flip at E16, only once.
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk($sformatf("long_E%0d_press", i), press,      i == 6);
      chk($sformatf("long_E%0d_level", i), level,      i >= 6);
      chk($sformatf("long_E%0d_long", i),  long_press, i == 16);
      chk($sformatf("long_E%0d_mode", i),  mode_sel,   i >= 16);
    end

    // Clean release from HELD: release at E6, mode_sel stays set.
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk($sformatf("rel_E%0d_release", i), release_pulse, i == 6);
      chk($sformatf("rel_E%0d_level", i),   level,         i < 6);
      chk($sformatf("rel_E%0d_mode", i),    mode_sel,      1'b1);
      chk($sformatf("rel_E%0d_long", i),    long_press,    1'b0);
    end

    // Release bounce at hold count 3: synchronised pin reads 0,0 at E10/E11,
    // then 1 again; the count resumes at 3 so long_press lands on E19.
    for (int i = 0; i < 22; i++) begin
      step((i == 8 || i == 9) ? 1'b0 : 1'b1);
      chk($sformatf("bnc_E%0d_press", i),   press,         i == 6);
      chk($sformatf("bnc_E%0d_level", i),   level,         i >= 6);
      chk($sformatf("bnc_E%0d_release", i), release_pulse, 1'b0);
      chk($sformatf("bnc_E%0d_long", i),    long_press,    i == 19);
      chk($sformatf("bnc_E%0d_mode", i),    mode_sel,      i < 19);
    end
    repeat (10) step(1'b0);

    // Bring mode_sel back to 1, then reset while debouncing a new press.
    repeat (20) step(1'b1);
    repeat (10) step(1'b0);
    chk("pre_rst_mode", mode_sel, 1'b1);
    repeat (4) step(1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_level",   level,         1'b0);
    chk("midrst_press",   press,         1'b0);
    chk("midrst_release", release_pulse, 1'b0);
    chk("midrst_long",    long_press,    1'b0);
    chk("midrst_mode",    mode_sel,      1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1);
      chk($sformatf("post_rst_edge%0d_press", k), press, k == 7);
      chk($sformatf("post_rst_edge%0d_level", k), level, k >= 7);
    end

    // Random bouncy bursts with occasional mid-operation resets.
    do_reset(1'b0);
    lvl = 1'b0;
    for (int b = 0; b < 160; b++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 2) == 0) len = int'($urandom_range(1, 3));
      else len = int'($urandom_range(5, 24));
      for (int c = 0; c < len; c++) begin
        step(lvl);
        chk_model("rnd");
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset(lvl);
        chk_model("rnd_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
